// File: rtl/servant_sleep_ctrl_pkg.sv
// Shared encodings for the servant sleep/wake controller: FSM states,
// register offsets and STATUS bit positions.
package servant_sleep_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_WAKE  = 2'd2;

    localparam logic [1:0] REG_MASK      = 2'd0;
    localparam logic [1:0] REG_PENDING   = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_SLEEP_CNT = 2'd3;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_SLEEP_BIT = 2;
    localparam int STATUS_READY_BIT = 3;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/servant_sleep_ctrl_if.sv
// Wishbone register-slave bundle for the sleep controller (32-bit data,
// 2-bit word address, single-strobe classic cycles).
interface servant_sleep_ctrl_if;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport slave  (input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
                    output o_wb_rdt, o_wb_ack);
    modport master (output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
                    input  o_wb_rdt, o_wb_ack);
endinterface

// File: rtl/servant_sync_ff.sv
// Single-bit synchroniser chain, STAGES flops deep, cleared by reset.
module servant_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '0;
        else        chain <= (chain << 1) | STAGES'(d);
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/servant_sleep_ctrl.sv
// Sleep/wake controller: gates the core clock on WFI, latches masked wake
// sources, holds the core stalled for a settle window after wake.
module servant_sleep_ctrl
    import servant_sleep_ctrl_pkg::*;
#(
    parameter int NUM_WAKE    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WAKE_DELAY  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sleep_req,
    input  logic                i_wakeup_req,
    input  logic [NUM_WAKE-1:0] i_wake,
    output logic                o_sleep,
    output logic                o_ready,
    output logic                o_wake_irq,
    servant_sleep_ctrl_if.slave wb
);
    localparam int             DW       = cnt_width(WAKE_DELAY);
    localparam logic [DW-1:0]  DLY_INIT = DW'(WAKE_DELAY);

    logic [NUM_WAKE-1:0] wake_s;
    logic [NUM_WAKE-1:0] mask;
    logic [NUM_WAKE-1:0] pending;
    logic [CNT_W-1:0]    sleep_cnt;
    logic [1:0]          state;
    logic [DW-1:0]       dly;
    logic [31:0]         rdata;
    logic                in_sleep, in_wake, in_run;
    logic                acc, wr, enter_sleep;
    logic                unused_dat;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign wake_s = i_wake;
        end else begin : g_sync
            servant_sync_ff #(.STAGES(SYNC_STAGES)) u_sync [NUM_WAKE-1:0] (
                .clk   (i_clk),
                .rst_n (i_rst_n),
                .d     (i_wake),
                .q     (wake_s)
            );
        end
    endgenerate

    // Code 3 is unreachable but must behave as RUN.
    assign in_sleep    = (state == ST_SLEEP);
    assign in_wake     = (state == ST_WAKE);
    assign in_run      = !in_sleep && !in_wake;
    assign o_sleep     = in_sleep;
    assign o_ready     = in_run;
    assign o_wake_irq  = |(pending & mask);
    assign enter_sleep = in_run && i_sleep_req && !i_wakeup_req && !o_wake_irq;

    // Register access completes on the edge that raises ack.
    assign acc        = wb.i_wb_cyc && !wb.o_wb_ack;
    assign wr         = acc && wb.i_wb_we;
    assign unused_dat = &{1'b0, wb.i_wb_dat[31:NUM_WAKE]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
            dly   <= '0;
        end else if (in_sleep) begin
            if (i_wakeup_req || o_wake_irq) begin
                state <= ST_WAKE;
                dly   <= DLY_INIT;
            end
        end else if (in_wake) begin
            if (dly == '0) state <= ST_RUN;
            else           dly   <= dly - 1'b1;
        end else begin
            state <= enter_sleep ? ST_SLEEP : ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mask      <= '1;
            pending   <= '0;
            sleep_cnt <= '0;
        end else begin
            if (wr && wb.i_wb_adr == REG_MASK)
                mask <= wb.i_wb_dat[NUM_WAKE-1:0];
            // Sources still asserted re-set the bit in the same cycle as a W1C.
            if (wr && wb.i_wb_adr == REG_PENDING)
                pending <= (pending & ~wb.i_wb_dat[NUM_WAKE-1:0]) | wake_s;
            else
                pending <= pending | wake_s;
            if (wr && wb.i_wb_adr == REG_SLEEP_CNT)
                sleep_cnt <= '0;
            else if (enter_sleep && sleep_cnt != '1)
                sleep_cnt <= sleep_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        rdata = '0;
        case (wb.i_wb_adr)
            REG_MASK:    rdata[NUM_WAKE-1:0] = mask;
            REG_PENDING: rdata[NUM_WAKE-1:0] = pending;
            REG_STATUS: begin
                rdata[STATUS_STATE_LSB +: 2] = state;
                rdata[STATUS_SLEEP_BIT]      = o_sleep;
                rdata[STATUS_READY_BIT]      = o_ready;
            end
            default:     rdata[CNT_W-1:0] = sleep_cnt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_rdt <= '0;
        end else begin
            wb.o_wb_ack <= acc;
            wb.o_wb_rdt <= acc ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed bench for servant_sleep_ctrl: stimulus pushes expected register
// reads into a scoreboard, a negedge monitor pops them on each ack.
module tb_servant_sleep_ctrl;
    import servant_sleep_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sleep_req, wakeup_req;
    logic [1:0] wake;
    logic       sleep, ready, wake_irq;

    servant_sleep_ctrl_if bus();

    servant_sleep_ctrl #(.NUM_WAKE(2), .SYNC_STAGES(2), .WAKE_DELAY(4), .CNT_W(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sleep_req  (sleep_req),
        .i_wakeup_req (wakeup_req),
        .i_wake       (wake),
        .o_sleep      (sleep),
        .o_ready      (ready),
        .o_wake_irq   (wake_irq),
        .wb           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [1:0]  adr;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_wb_ack === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 expected=0");
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.rd) check($sformatf("rd_adr%0d", mon_e.adr), bus.o_wb_rdt, mon_e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] v);
        sbq.push_back('{rd: 1'b1, adr: a, val: v});
        bus.i_wb_adr = a; bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b1;
        @(negedge clk);
        bus.i_wb_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        sbq.push_back('{rd: 1'b0, adr: a, val: 32'h0});
        bus.i_wb_adr = a; bus.i_wb_dat = d; bus.i_wb_we = 1'b1; bus.i_wb_cyc = 1'b1;
        @(negedge clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_sleep();
        sleep_req = 1'b1; @(negedge clk); sleep_req = 1'b0;
    endtask

    task automatic pulse_wake();
        wakeup_req = 1'b1; @(negedge clk); wakeup_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sleep_req = 1'b0; wakeup_req = 1'b0; wake = 2'b00;
        bus.i_wb_adr = 2'd0; bus.i_wb_dat = 32'h0; bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state
        check("rst_sleep", sleep, 0);
        check("rst_ready", ready, 1);
        check("rst_irq", wake_irq, 0);
        bus_rd(REG_STATUS, 32'h8);
        bus_rd(REG_MASK, 32'h3);
        bus_rd(REG_PENDING, 32'h0);
        bus_rd(REG_SLEEP_CNT, 32'h0);

        // Dirty state, sleep, wake, then reset with delay counter at 2
        bus_wr(REG_MASK, 32'h1);
        pulse_sleep();
        check("sleep_osleep", sleep, 1);
        check("sleep_ready", ready, 0);
        bus_rd(REG_SLEEP_CNT, 32'h1);
        bus_rd(REG_STATUS, 32'h5);
        pulse_wake();
        check("wake_osleep", sleep, 0);
        check("wake_ready", ready, 0);
        bus_rd(REG_STATUS, 32'h2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("midwake_rst_ready", ready, 1);
        check("midwake_rst_sleep", sleep, 0);
        bus_rd(REG_MASK, 32'h3);
        bus_rd(REG_PENDING, 32'h0);
        bus_rd(REG_SLEEP_CNT, 32'h0);
        bus_rd(REG_STATUS, 32'h8);

        // Wake settle window: WAKE_DELAY+1 cycles of o_ready=0
        pulse_sleep();
        check("t2_sleep", sleep, 1);
        pulse_wake();
        check("t2_wake_sleep", sleep, 0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t2_wake_hold", ready, 0);
        end
        step(1);
        check("t2_wake_done", ready, 1);
        bus_rd(REG_SLEEP_CNT, 32'h1);

        // sleep and wakeup in the same cycle: wake wins
        sleep_req = 1'b1; wakeup_req = 1'b1;
        step(1);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        check("t3_sleep", sleep, 0);
        check("t3_ready", ready, 1);
        bus_rd(REG_SLEEP_CNT, 32'h1);

        // Masked source latches pending but does not wake; unmask wakes next edge
        bus_wr(REG_MASK, 32'h1);
        pulse_sleep();
        wake = 2'b10;
        step(4);
        check("t4_asleep", sleep, 1);
        check("t4_irq", wake_irq, 0);
        wake = 2'b00;
        bus_rd(REG_PENDING, 32'h2);
        bus_rd(REG_STATUS, 32'h5);
        sbq.push_back('{rd: 1'b0, adr: REG_MASK, val: 32'h0});
        bus.i_wb_adr = REG_MASK; bus.i_wb_dat = 32'h3; bus.i_wb_we = 1'b1; bus.i_wb_cyc = 1'b1;
        @(negedge clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        check("t4_irq_unmask", wake_irq, 1);
        check("t4_still_asleep", sleep, 1);
        @(negedge clk);
        check("t4_woke_sleep", sleep, 0);
        check("t4_woke_ready", ready, 0);
        bus_wr(REG_PENDING, 32'h2);
        step(3);
        check("t4_run", ready, 1);
        bus_rd(REG_PENDING, 32'h0);
        bus_rd(REG_SLEEP_CNT, 32'h2);

        // Held source beats W1C; pending irq blocks sleep entry
        wake = 2'b01;
        step(4);
        bus_wr(REG_PENDING, 32'h1);
        bus_rd(REG_PENDING, 32'h1);
        pulse_sleep();
        check("t5_irq_blocks_sleep", sleep, 0);
        bus_rd(REG_SLEEP_CNT, 32'h2);
        wake = 2'b00;
        step(3);
        bus_wr(REG_PENDING, 32'h1);
        bus_rd(REG_PENDING, 32'h0);
        check("t5_irq_clear", wake_irq, 0);

        // Counter clear and saturation at 2'b11
        bus_wr(REG_SLEEP_CNT, 32'h0);
        bus_rd(REG_SLEEP_CNT, 32'h0);
        for (int k = 0; k < 4; k++) begin
            pulse_sleep();
            pulse_wake();
            step(5);
            check("t6_cycle_ready", ready, 1);
        end
        bus_rd(REG_SLEEP_CNT, 32'h3);

        // Counter write beats same-cycle increment
        sbq.push_back('{rd: 1'b0, adr: REG_SLEEP_CNT, val: 32'h0});
        bus.i_wb_adr = REG_SLEEP_CNT; bus.i_wb_dat = 32'h0; bus.i_wb_we = 1'b1; bus.i_wb_cyc = 1'b1;
        sleep_req = 1'b1;
        @(negedge clk);
        sleep_req = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        check("t7_sleep", sleep, 1);
        @(negedge clk);
        bus_rd(REG_SLEEP_CNT, 32'h0);
        pulse_wake();
        step(5);
        check("t7_ready", ready, 1);

        step(2);
        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
